// File: rtl/gpc_bus_ctrl.sv
// gpc_bus_ctrl
//
// Downstream memory and I/O controller for the GPC CPU bus. It is the only
// responder on the bus: it decodes the 16-bit CPU address and the read/write
// strobe, and it serves the shared 8-bit data bus.
//
// Resources behind the bus:
//   0x0000 .. 2^RAM_AW-1  byte RAM. Writes land on every rw=1 edge.
//   0xFF00  W: push to TX FIFO (dropped and tx_ovf set if full)   R: 0x00
//   0xFF01  W: pop RX FIFO (value ignored)                        R: RX head
//   0xFF02  W: bit3=1 clears tx_ovf    R: {4'b0, tx_ovf, rx_nonempty, tx_full, tx_empty}
//   0xFF03  W: snapshot <- timer       R: snapshot[15:8]
//   0xFF04  W: no effect               R: snapshot[7:0]
//
// Reads are purely combinational from address and have no side effects.
// I/O writes are deferred. Each rw=1 edge on an I/O address latches the
// address and data; the first rw=0 edge afterwards commits exactly once, so a
// CPU write burst has a single side effect that uses its final data.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   address, rw, data    CPU bus (rw=1 write; data is driven only while rw=0)
//   tx_data/valid/ready  TX stream toward the sink
//   rx_data/valid/ready  RX stream from the source
//
// Handshake: on both streams a byte moves on a rising edge where valid and
// ready are both 1. valid does not wait for ready, and ready depends only on
// the FIFO count.

module gpc_bus_ctrl #(
  parameter int    RAM_AW    = 12,
  parameter int    TX_DEPTH  = 4,
  parameter int    RX_DEPTH  = 4,
  parameter int    TIMER_DIV = 16,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic        rw,
  inout  wire  [7:0]  data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int TAW       = $clog2(TX_DEPTH);
  localparam int RAW       = $clog2(RX_DEPTH);
  localparam int PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  // ---------------------------------------------------------------- decode
  logic ram_sel, io_sel;
  assign ram_sel = ({16'd0, address} < 32'(RAM_DEPTH));
  assign io_sel  = (address[15:3] == 13'h1FE0) && (address[2:0] <= 3'd4);

  // ---------------------------------------------------------------- RAM
  logic [7:0] ram [0:RAM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (rw && ram_sel)
      ram[address[RAM_AW-1:0]] <= data;
  end

  // ---------------------------------------------------------------- deferred I/O write
  logic       pend;
  logic [2:0] pend_addr;
  logic [7:0] pend_data;
  logic       commit;

  // A burst that wanders out of the I/O range keeps the last I/O latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_addr <= 3'd0;
      pend_data <= 8'h00;
    end else if (rw) begin
      if (io_sel) begin
        pend      <= 1'b1;
        pend_addr <= address[2:0];
        pend_data <= data;
      end
    end else if (pend) begin
      pend <= 1'b0;
    end
  end

  assign commit = !rw && pend;

  logic tx_push, rx_pop_req, ovf_clr, snap_ld;
  assign tx_push    = commit && (pend_addr == 3'd0);
  assign rx_pop_req = commit && (pend_addr == 3'd1);
  assign ovf_clr    = commit && (pend_addr == 3'd2) && pend_data[3];
  assign snap_ld    = commit && (pend_addr == 3'd3);

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]     tx_mem [0:TX_DEPTH-1];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [TAW:0]   tx_cnt;
  logic tx_full, tx_wr, tx_rd, tx_ovf;

  assign tx_full  = (tx_cnt == (TAW+1)'(TX_DEPTH));
  assign tx_valid = (tx_cnt != '0);
  assign tx_data  = tx_valid ? tx_mem[tx_rp] : 8'h00;
  // Fullness is judged on the pre-pop count: a same-cycle pop does not
  // make room for the push.
  assign tx_wr    = tx_push && !tx_full;
  assign tx_rd    = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (tx_wr)
      tx_mem[tx_wp] <= pend_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (tx_wr) tx_wp <= tx_wp + 1'b1;
      if (tx_rd) tx_rp <= tx_rp + 1'b1;
      case ({tx_wr, tx_rd})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      if (tx_push && tx_full) tx_ovf <= 1'b1;
      else if (ovf_clr)       tx_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]     rx_mem [0:RX_DEPTH-1];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [RAW:0]   rx_cnt;
  logic rx_nonempty, rx_wr, rx_rd;
  logic [7:0] rx_head;

  assign rx_nonempty = (rx_cnt != '0);
  assign rx_ready    = (rx_cnt != (RAW+1)'(RX_DEPTH));
  assign rx_head     = rx_nonempty ? rx_mem[rx_rp] : 8'h00;
  assign rx_wr       = rx_valid && rx_ready;
  assign rx_rd       = rx_pop_req && rx_nonempty;

  always_ff @(posedge clk) begin
    if (rx_wr)
      rx_mem[rx_wp] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_wr) rx_wp <= rx_wp + 1'b1;
      if (rx_rd) rx_rp <= rx_rp + 1'b1;
      case ({rx_wr, rx_rd})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------- timer
  logic [PW-1:0] presc;
  logic [15:0]   timer, snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      timer <= 16'h0000;
      snap  <= 16'h0000;
    end else begin
      if (presc == PW'(TIMER_DIV - 1)) begin
        presc <= '0;
        timer <= timer + 16'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      // The snapshot takes the timer value from before this edge.
      if (snap_ld) snap <= timer;
    end
  end

  // ---------------------------------------------------------------- read path
  logic [7:0] status, rd_data;
  assign status = {4'b0000, tx_ovf, rx_nonempty, tx_full, !tx_valid};

  always_comb begin
    rd_data = 8'h00;
    if (ram_sel) begin
      rd_data = ram[address[RAM_AW-1:0]];
    end else begin
      case (address)
        16'hFF01: rd_data = rx_head;
        16'hFF02: rd_data = status;
        16'hFF03: rd_data = snap[15:8];
        16'hFF04: rd_data = snap[7:0];
        default:  rd_data = 8'h00;
      endcase
    end
  end

  assign data = rw ? 8'hzz : rd_data;

endmodule

// File: tb/tb_gpc_bus_ctrl.sv
// Directed bench for gpc_bus_ctrl. The main instance runs with TIMER_DIV=4;
// a second instance with TIMER_DIV=1 runs from the start so its timer can be
// observed wrapping through 0xFFFF near the end of the run.
module tb_gpc_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] address = 16'h0000;
    logic        rw = 1'b0;
    logic [7:0]  cpu_data = 8'h00;
    wire  [7:0]  data;
    wire  [7:0]  tx_data;
    wire         tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    wire         rx_ready;

    logic        rst_n2 = 1'b0;
    logic [15:0] address2 = 16'h0000;
    logic        rw2 = 1'b0;
    logic [7:0]  cpu_data2 = 8'h00;
    wire  [7:0]  data2;
    wire  [7:0]  tx_data2;
    wire         tx_valid2;
    wire         rx_ready2;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt2     = 0;

    assign data  = rw  ? cpu_data  : 8'hzz;
    assign data2 = rw2 ? cpu_data2 : 8'hzz;

    gpc_bus_ctrl #(.RAM_AW(12), .TX_DEPTH(4), .RX_DEPTH(4), .TIMER_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .rw(rw), .data(data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    gpc_bus_ctrl #(.RAM_AW(12), .TX_DEPTH(4), .RX_DEPTH(4), .TIMER_DIV(1)) dut2 (
        .clk(clk), .rst_n(rst_n2), .address(address2), .rw(rw2), .data(data2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(1'b0),
        .rx_data(8'h00), .rx_valid(1'b0), .rx_ready(rx_ready2)
    );

    // ------------------------------------------------------------ clock / reset
    always #5 clk = ~clk;

    // Edges seen by dut2 since its reset was released.
    always @(posedge clk) if (rst_n2) cnt2 <= cnt2 + 1;

    // All driving happens at the falling edge; tick advances one full cycle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rw = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; address = 16'h0000;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------ drivers
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int edges);
        address = a; cpu_data = d; rw = 1'b1;
        repeat (edges) tick();
        rw = 1'b0;
        tick();
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] v);
        rw = 1'b0; address = a;
        #1;
        v = data;
    endtask

    task automatic cpu2_read(input logic [15:0] a, output logic [7:0] v);
        rw2 = 1'b0; address2 = a;
        #1;
        v = data2;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        logic [7:0] v;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); end
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL rst_status got=%h exp=01", v); end
        cpu_read(16'hFF01, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_rx_head got=%h exp=00", v); end
        cpu_read(16'hFF04, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_snap_lo got=%h exp=00", v); end
    endtask

    task automatic test_ram();
        logic [7:0] v;
        address = 16'h0123; rw = 1'b1;
        cpu_data = 8'h00; tick();
        cpu_data = 8'h5A; tick();
        rw = 1'b0; tick();
        cpu_read(16'h0123, v);
        n_checks++; if (v !== 8'h5A) begin n_fail++; $display("FAIL ram_0123 got=%h exp=5A", v); end
        cpu_write(16'h0FFF, 8'hC3, 1);
        cpu_read(16'h0FFF, v);
        n_checks++; if (v !== 8'hC3) begin n_fail++; $display("FAIL ram_top got=%h exp=C3", v); end
        cpu_read(16'h1123, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL ram_outside got=%h exp=00", v); end
        cpu_read(16'hFF05, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL unmapped_ff05 got=%h exp=00", v); end
        cpu_read(16'h0123, v);
        n_checks++; if (v !== 8'h5A) begin n_fail++; $display("FAIL ram_0123_again got=%h exp=5A", v); end
    endtask

    task automatic test_tx_burst();
        logic [7:0] v;
        do_reset();
        cpu_write(16'hFF00, 8'h41, 2);
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL tx_one_status got=%h exp=00", v); end
        n_checks++; if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_one_head got=%h/%b exp=41/1", tx_data, tx_valid); end
        cpu_write(16'hFF00, 8'h42, 1);
        cpu_write(16'hFF00, 8'h43, 1);
        cpu_write(16'hFF00, 8'h44, 1);
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL tx_full_status got=%h exp=02", v); end
        cpu_write(16'hFF00, 8'h45, 1);
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h0A) begin n_fail++; $display("FAIL tx_ovf_status got=%h exp=0A", v); end
        n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_head_after_drop got=%h exp=41", tx_data); end
        cpu_write(16'hFF02, 8'hF7, 1);
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h0A) begin n_fail++; $display("FAIL ovf_keep_bit3_0 got=%h exp=0A", v); end
        cpu_write(16'hFF02, 8'h08, 1);
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL ovf_clear got=%h exp=02", v); end
    endtask

    task automatic test_tx_drain();
        logic [7:0] v;
        do_reset();
        cpu_write(16'hFF00, 8'h01, 1);
        cpu_write(16'hFF00, 8'h02, 1);
        cpu_write(16'hFF00, 8'h03, 1);
        tx_ready = 1'b1;
        n_checks++; if (tx_data !== 8'h01 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL drain_0 got=%h/%b exp=01/1", tx_data, tx_valid); end
        tick();
        n_checks++; if (tx_data !== 8'h02 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL drain_1 got=%h/%b exp=02/1", tx_data, tx_valid); end
        tick();
        n_checks++; if (tx_data !== 8'h03 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL drain_2 got=%h/%b exp=03/1", tx_data, tx_valid); end
        tick();
        n_checks++; if (tx_data !== 8'h00 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%h/%b exp=00/0", tx_data, tx_valid); end
        tx_ready = 1'b0;
        cpu_write(16'hFF00, 8'h10, 1);
        cpu_write(16'hFF00, 8'h11, 1);
        cpu_write(16'hFF00, 8'h12, 1);
        cpu_write(16'hFF00, 8'h13, 1);
        // Commit a push on the same edge as a pop while full.
        address = 16'hFF00; cpu_data = 8'h14; rw = 1'b1;
        tick();
        rw = 1'b0; tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL full_pop_status got=%h exp=08", v); end
        n_checks++; if (tx_data !== 8'h11) begin n_fail++; $display("FAIL full_pop_head got=%h exp=11", tx_data); end
        tx_ready = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_drained got=%b exp=0 (14 must be dropped)", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        logic [7:0] v;
        logic [7:0] offer [5];
        offer[0] = 8'h11; offer[1] = 8'h22; offer[2] = 8'h33; offer[3] = 8'h44; offer[4] = 8'h55;
        do_reset();
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_data = offer[i];
            n_checks++;
            if (rx_ready !== (i < 4)) begin n_fail++; $display("FAIL rx_ready_%0d got=%b exp=%b", i, rx_ready, (i < 4)); end
            tick();
        end
        rx_valid = 1'b0;
        cpu_read(16'hFF01, v);
        n_checks++; if (v !== 8'h11) begin n_fail++; $display("FAIL rx_head got=%h exp=11", v); end
        tick(); tick();
        cpu_read(16'hFF01, v);
        n_checks++; if (v !== 8'h11) begin n_fail++; $display("FAIL rx_head_reread got=%h exp=11", v); end
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h05) begin n_fail++; $display("FAIL rx_status got=%h exp=05", v); end
        cpu_write(16'hFF01, 8'h00, 1);
        cpu_read(16'hFF01, v);
        n_checks++; if (v !== 8'h22) begin n_fail++; $display("FAIL rx_after_pop got=%h exp=22", v); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_after_pop got=%b exp=1", rx_ready); end
        cpu_write(16'hFF01, 8'h00, 1);
        cpu_write(16'hFF01, 8'h00, 1);
        cpu_read(16'hFF01, v);
        n_checks++; if (v !== 8'h44) begin n_fail++; $display("FAIL rx_last got=%h exp=44", v); end
        cpu_write(16'hFF01, 8'h00, 1);
        cpu_write(16'hFF01, 8'h00, 1);
        cpu_read(16'hFF01, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rx_empty_head got=%h exp=00", v); end
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL rx_empty_status got=%h exp=01", v); end
    endtask

    task automatic test_range_exit();
        logic [7:0] v;
        do_reset();
        rw = 1'b1;
        address = 16'hFF00; cpu_data = 8'h77; tick();
        address = 16'h0200; cpu_data = 8'h99; tick();
        rw = 1'b0; tick();
        n_checks++; if (tx_data !== 8'h77 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL range_exit_tx got=%h/%b exp=77/1", tx_data, tx_valid); end
        cpu_read(16'h0200, v);
        n_checks++; if (v !== 8'h99) begin n_fail++; $display("FAIL range_exit_ram got=%h exp=99", v); end
        cpu_write(16'hFF04, 8'h55, 1);
        cpu_write(16'hFF05, 8'h66, 1);
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL noeffect_status got=%h exp=00", v); end
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL noeffect_single got=%b exp=0", tx_valid); end
    endtask

    task automatic test_timer();
        logic [7:0] v;
        do_reset();
        repeat (1199) tick();
        cpu_write(16'hFF03, 8'h00, 1);
        cpu_read(16'hFF03, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL timer_hi got=%h exp=01", v); end
        cpu_read(16'hFF04, v);
        n_checks++; if (v !== 8'h2C) begin n_fail++; $display("FAIL timer_lo got=%h exp=2C", v); end
        repeat (20) tick();
        cpu_read(16'hFF04, v);
        n_checks++; if (v !== 8'h2C) begin n_fail++; $display("FAIL timer_snap_hold got=%h exp=2C", v); end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] v;
        do_reset();
        rx_valid = 1'b1; rx_data = 8'h5C; tick(); rx_valid = 1'b0;
        cpu_write(16'hFF00, 8'h33, 1);
        cpu_write(16'hFF03, 8'h00, 1);
        address = 16'hFF00; cpu_data = 8'hAB; rw = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_tx got=%h/%b exp=00/0", tx_data, tx_valid); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rx_ready got=%b exp=1", rx_ready); end
        tick();
        rw = 1'b0;
        rst_n = 1'b1;
        tick();
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_commit got=%b exp=0", tx_valid); end
        cpu_read(16'hFF02, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL mid_rst_status got=%h exp=01", v); end
        cpu_read(16'hFF01, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL mid_rst_rx_head got=%h exp=00", v); end
        cpu_read(16'hFF04, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL mid_rst_snap got=%h exp=00", v); end
    endtask

    task automatic test_timer_wrap();
        logic [7:0] v;
        int guard = 0;
        while (cnt2 != 65534 && guard < 70000) begin
            tick();
            guard++;
        end
        n_checks++; if (cnt2 != 65534) begin n_fail++; $display("FAIL wrap_wait got=%0d exp=65534", cnt2); end
        // Latch on edge 65535, commit on edge 65536: timer before it is 0xFFFF.
        address2 = 16'hFF03; rw2 = 1'b1; tick();
        rw2 = 1'b0; tick();
        cpu2_read(16'hFF03, v);
        n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL wrap_pre_hi got=%h exp=FF", v); end
        cpu2_read(16'hFF04, v);
        n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL wrap_pre_lo got=%h exp=FF", v); end
        // Commit on edge 65538: timer has wrapped to 0 and counted once.
        address2 = 16'hFF03; rw2 = 1'b1; tick();
        rw2 = 1'b0; tick();
        cpu2_read(16'hFF03, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL wrap_post_hi got=%h exp=00", v); end
        cpu2_read(16'hFF04, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL wrap_post_lo got=%h exp=01", v); end
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        tick();
        tick();
        rst_n  = 1'b1;
        rst_n2 = 1'b1;
        test_reset();
        test_ram();
        test_tx_burst();
        test_tx_drain();
        test_rx();
        test_range_exit();
        test_timer();
        test_reset_mid_burst();
        test_timer_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
